mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential shift-add multiplier (start/done interface, W x W -> 2W) among NREQ requesters. It grants one requester at a time, drives and holds the operands, and keeps the multiplier start asserted until completion. It then returns the product to the granted requester and releases start so the multiplier's internal counter clears before the next operation. It sits between the requesting datapath blocks and the multiplier instance.

---
 rtl/mul_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sequencer sharing one start/done shift-add multiplier
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   req[NREQ]         per-requester request level, held until its rsp_valid
//   a_in, b_in        packed operands, requester k at [k*W +: W]
//   gnt[NREQ]         one-hot grant, high LOAD through DONE
//   rsp_valid[NREQ]   one-cycle result pulse for the granted requester
//   rsp_y[2W]         product, held until the next response
//   rsp_err           result came from a timeout (rsp_y = 0)
//   busy              controller not idle
//   mul_start         multiplier start level
//   mul_a, mul_b      multiplier operands
//   mul_y, mul_done   multiplier product and level-sensitive done
//
// Build option: define MULARB_SIGNED_EN for two's-complement operands
// (magnitudes go to the multiplier, the sign is reapplied to the product).
module mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 64,
    parameter int MUL_LAT = 66,
    parameter int TIMEOUT = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_y,
    output logic              rsp_err,
    output logic              busy,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_y,
    input  logic              mul_done
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE, ST_RELEASE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   idx_q, idx_d, ptr_q, ptr_d, pick, cand;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [W-1:0]    sel_a, sel_b, mag_a, mag_b;
    logic [2*W-1:0]  rsp_y_q, rsp_y_d, prod;
    logic            rsp_err_q, rsp_err_d;

    // Scan downward so the last hit, i.e. the nearest after the pointer, wins.
    always_comb begin
        pick = ptr_q;
        cand = ptr_q;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (req[cand]) pick = cand;
        end
    end

    assign sel_a = a_in[pick*W +: W];
    assign sel_b = b_in[pick*W +: W];

`ifdef MULARB_SIGNED_EN
    logic sign_q, sign_d;
    assign mag_a = sel_a[W-1] ? -sel_a : sel_a;
    assign mag_b = sel_b[W-1] ? -sel_b : sel_b;
    assign prod  = sign_q ? -mul_y : mul_y;
    assign sign_d = (state_q == ST_IDLE && |req) ? sel_a[W-1] ^ sel_b[W-1] : sign_q;
    always_ff @(posedge clk)
        if (!rst_n) sign_q <= 1'b0;
        else        sign_q <= sign_d;
`else
    assign mag_a = sel_a;
    assign mag_b = sel_b;
    assign prod  = mul_y;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        rsp_y_d   = rsp_y_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            ST_IDLE: if (|req) begin
                state_d = ST_LOAD;
                gnt_d   = NREQ'(1) << pick;
                idx_d   = pick;
                mul_a_d = mag_a;
                mul_b_d = mag_b;
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                // The latency floor rejects a done left high by the previous operation.
                if (mul_done && cnt_q >= CW'(MUL_LAT)) begin
                    rsp_y_d   = prod;
                    rsp_err_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = idx_q;
                gnt_d   = '0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= IW'(NREQ - 1);
            cnt_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            rsp_y_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            rsp_y_q   <= rsp_y_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // A requester that dropped req mid-operation gets no pulse.
    assign rsp_valid = (state_q == ST_DONE) ? gnt_q & req : '0;
    assign gnt       = gnt_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = state_q != ST_IDLE;
    assign mul_start = state_q == ST_LOAD || state_q == ST_RUN;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed self-checking bench for mul_arbiter with a behavioural multiplier
module tb_mul_arbiter;
    localparam int NREQ = 4, W = 64, MUL_LAT = 66, TIMEOUT = 96;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0, b_in = '0;
    logic [NREQ-1:0]   gnt, rsp_valid;
    logic [2*W-1:0]    rsp_y, mul_y;
    logic              rsp_err, busy, mul_start, mul_done;
    logic [W-1:0]      mul_a, mul_b;

    int mode = 0;
    int mcnt = 0;
    int total = 0, bad = 0;

    logic [NREQ-1:0] rv, exv;
    logic [2*W-1:0]  y;
    logic            e;
    int              ns;

    mul_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_y(mul_y), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    // mode 0: done after MUL_LAT start cycles; 1: done stuck high; 2: done never
    always @(posedge clk) mcnt <= mul_start ? mcnt + 1 : 0;
    assign mul_done = (mode == 1) || (mode == 0 && mcnt >= MUL_LAT);
    assign mul_y    = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[k*W +: W] = a;
        b_in[k*W +: W] = b;
    endtask

    task automatic wait_rsp(output logic [NREQ-1:0] r, output logic [2*W-1:0] yy,
                            output logic ee, output int n);
        r = '0; yy = '0; ee = 1'b0; n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (|rsp_valid) begin
                r = rsp_valid; yy = rsp_y; ee = rsp_err;
                break;
            end
            if (mul_start) n++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_y", rsp_y, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_mul_a", mul_a, 0);
        rst_n = 1'b1;

        set_ops(1, 3, 5); req = 4'b0010;
        @(negedge clk);
        chk("single_gnt", gnt, 4'b0010);
        chk("single_start", mul_start, 1);
        chk("single_mul_a", mul_a, 3);
        chk("single_mul_b", mul_b, 5);
        set_ops(1, 7, 7);
        wait_rsp(rv, y, e, ns);
        chk("single_rv", rv, 4'b0010);
        chk("single_y", y, 15);
        chk("single_err", e, 0);
        chk("single_start_len", ns + 1 >= MUL_LAT, 1);
        chk("done_start_low", mul_start, 0);
        req = '0;
        @(negedge clk);
        chk("release_start_low", mul_start, 0);
        chk("release_gnt", gnt, 0);
        chk("release_busy", busy, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);

        set_ops(0, '1, '1); req = 4'b0001;
        wait_rsp(rv, y, e, ns);
        chk("full_rv", rv, 4'b0001);
`ifdef MULARB_SIGNED_EN
        chk("full_y", y, 128'd1);
`else
        chk("full_y", y, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
`endif
        req = '0; repeat (2) @(negedge clk);

        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) set_ops(k, W'(k + 1), W'(k + 2));
        req = '1;
        for (int n = 0; n < 5; n++) begin
            wait_rsp(rv, y, e, ns);
            exv = NREQ'(1) << (n % NREQ);
            chk("rr_rv", rv, exv);
            chk("rr_y", y, 128'((n % NREQ + 1) * (n % NREQ + 2)));
        end
        req = '0; repeat (2) @(negedge clk);

        mode = 1; set_ops(1, 2, 3); req = 4'b0010;
        wait_rsp(rv, y, e, ns);
        chk("sticky_rv", rv, 4'b0010);
        chk("sticky_y", y, 6);
        chk("sticky_len", ns >= MUL_LAT + 1, 1);
        req = '0; repeat (2) @(negedge clk); mode = 0;

        mode = 2; set_ops(2, 4, 5); req = 4'b0100;
        wait_rsp(rv, y, e, ns);
        chk("to_rv", rv, 4'b0100);
        chk("to_err", e, 1);
        chk("to_y", y, 0);
        chk("to_len", ns >= TIMEOUT && ns <= TIMEOUT + 2, 1);
        req = '0; repeat (2) @(negedge clk); mode = 0;
        set_ops(3, 6, 7); req = 4'b1000;
        wait_rsp(rv, y, e, ns);
        chk("after_to_rv", rv, 4'b1000);
        chk("after_to_y", y, 42);
        chk("after_to_err", e, 0);
        req = '0; repeat (2) @(negedge clk);

        set_ops(2, 8, 9); req = 4'b1100;
        @(negedge clk);
        chk("drop_gnt", gnt, 4'b0100);
        repeat (10) @(negedge clk);
        req = 4'b1000;
        wait_rsp(rv, y, e, ns);
        chk("drop_next_rv", rv, 4'b1000);
        chk("drop_next_y", y, 42);
        req = '0; repeat (2) @(negedge clk);

        set_ops(1, 1, 1); req = 4'b0010;
        wait_rsp(rv, y, e, ns);
        chk("ptr1_rv", rv, 4'b0010);
        chk("ptr1_y", y, 1);
        req = '0; repeat (2) @(negedge clk);

        set_ops(2, 8, 9); req = 4'b0100;
        repeat (20) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", mul_start, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_valid", rsp_valid, 0);
        rst_n = 1'b1; set_ops(0, 9, 9); req = 4'b0111;
        @(negedge clk);
        chk("postrst_gnt", gnt, 4'b0001);
        wait_rsp(rv, y, e, ns);
        chk("postrst_rv", rv, 4'b0001);
        chk("postrst_y", y, 81);
        req = '0; repeat (2) @(negedge clk);

`ifdef MULARB_SIGNED_EN
        set_ops(1, -64'd3, 64'd5); req = 4'b0010;
        wait_rsp(rv, y, e, ns);
        chk("signed_rv", rv, 4'b0010);
        chk("signed_y", y, -128'd15);
        req = '0; repeat (2) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
